// File: rtl/core_config_pkg.sv
// Shared core configuration: default scoreboard geometry and the writeback port bundle.
package core_config_pkg;

   localparam int DEFAULT_REG_COUNT = 32;
   localparam int DEFAULT_RA_W      = $clog2(DEFAULT_REG_COUNT);
   localparam int NUM_WB_PORTS      = 2;
   localparam int DEFAULT_TAG_W     = 4;

   // One commit-bus port at the default geometry.
   typedef struct packed {
      logic                     valid;
      logic [DEFAULT_RA_W-1:0]  addr;
      logic [DEFAULT_TAG_W-1:0] tag;
   } wb_port_t;

endpackage

// File: rtl/scoreboard_clear_decode.sv
// Maps the writeback ports to a per-register clear vector.
// A register clears only when it is busy and a port's tag matches its recorded producer.
module scoreboard_clear_decode #(
   parameter int REG_COUNT = 32,
   parameter int NUM_WB    = 2,
   parameter int TAG_W     = 4,
   parameter int RA_W      = $clog2(REG_COUNT)
) (
   input  logic [NUM_WB-1:0]                 wb_valid_i,
   input  logic [NUM_WB*RA_W-1:0]            wb_addr_i,
   input  logic [NUM_WB*TAG_W-1:0]           wb_tag_i,
   input  logic [REG_COUNT-1:0]              busy_i,
   input  logic [REG_COUNT-1:0][TAG_W-1:0]   tag_i,
   output logic [REG_COUNT-1:0]              clear_o
);

   always_comb begin
      clear_o = '0;
      for (int p = 0; p < NUM_WB; p++) begin
         for (int r = 0; r < REG_COUNT; r++) begin
            // Several ports hitting the same register simply OR together.
            if (wb_valid_i[p] && (wb_addr_i[p*RA_W +: RA_W] == RA_W'(r)) && busy_i[r] &&
                (tag_i[r] == wb_tag_i[p*TAG_W +: TAG_W])) begin
               clear_o[r] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/scoreboard_tagged.sv
// Register scoreboard with producer tags: locks targets on issue and releases them
// only on a matching-tag writeback, so a superseded writer cannot unlock a re-issued target.
module scoreboard_tagged
   import core_config_pkg::*;
#(
   parameter int REG_COUNT          = DEFAULT_REG_COUNT,
   parameter int NUM_WB             = NUM_WB_PORTS,
   parameter int TAG_W              = DEFAULT_TAG_W,
   parameter bit ZERO_REG_HARDWIRED = 1'b1,
   localparam int RA_W              = $clog2(REG_COUNT),
   localparam int CNT_W             = $clog2(REG_COUNT + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic [RA_W-1:0]         issue_rd,
   input  logic [RA_W-1:0]         issue_rs1,
   input  logic [RA_W-1:0]         issue_rs2,
   input  logic                    issue_has_rd,
   input  logic [TAG_W-1:0]        issue_tag,
   output logic [TAG_W-1:0]        rs1_tag,
   output logic [TAG_W-1:0]        rs2_tag,
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*RA_W-1:0]  wb_addr,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag,
   input  logic                    flush,
   output logic [CNT_W-1:0]        busy_count
);

   logic [REG_COUNT-1:0]            busy_q, busy_d;
   logic [REG_COUNT-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [CNT_W-1:0]                count_q, count_d;
   logic [REG_COUNT-1:0]            clear, avail, zero_mask;
   logic                            rd_locks, lock;

   function automatic logic [CNT_W-1:0] popcount(input logic [REG_COUNT-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < REG_COUNT; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   scoreboard_clear_decode #(
      .REG_COUNT (REG_COUNT),
      .NUM_WB    (NUM_WB),
      .TAG_W     (TAG_W),
      .RA_W      (RA_W)
   ) u_clear_decode (
      .wb_valid_i (wb_valid),
      .wb_addr_i  (wb_addr),
      .wb_tag_i   (wb_tag),
      .busy_i     (busy_q),
      .tag_i      (tag_q),
      .clear_o    (clear)
   );

   assign zero_mask = ZERO_REG_HARDWIRED ? REG_COUNT'(1) : '0;
   assign avail     = ~busy_q | clear | zero_mask;

   // Handshake: an issue transfers on a cycle where issue_valid && issue_ready.
   // issue_ready is a function of state, writebacks and flush only, never of issue_valid.
   assign issue_ready = !flush && avail[issue_rs1] && avail[issue_rs2] &&
                        (!issue_has_rd || avail[issue_rd]);
   assign rd_locks    = issue_has_rd && !(ZERO_REG_HARDWIRED && (issue_rd == '0));
   assign lock        = issue_valid && issue_ready && rd_locks;

   always_comb begin
      busy_d = busy_q & ~clear;
      tag_d  = tag_q;
      // Applied after the clear so a re-issue of rd wins over its own writeback.
      if (lock) begin
         busy_d[issue_rd] = 1'b1;
         tag_d[issue_rd]  = issue_tag;
      end
      if (flush) busy_d = '0;
      busy_d  = busy_d & ~zero_mask;
      count_d = popcount(busy_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         tag_q   <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         tag_q   <= tag_d;
         count_q <= count_d;
      end
   end

   assign rs1_tag    = tag_q[issue_rs1];
   assign rs2_tag    = tag_q[issue_rs2];
   assign busy_count = count_q;

endmodule

// File: tb/tb_scoreboard_tagged.sv
// Bench for scoreboard_tagged: directed scenarios plus random traffic, checked by a
// negedge monitor against expectations queued from an array-based reference model.
module tb_scoreboard_tagged;
   import core_config_pkg::*;

   localparam int REG_COUNT = DEFAULT_REG_COUNT;
   localparam int NUM_WB    = NUM_WB_PORTS;
   localparam int TAG_W     = DEFAULT_TAG_W;
   localparam int RA_W      = DEFAULT_RA_W;
   localparam int CNT_W     = $clog2(REG_COUNT + 1);
   localparam int EXP_W     = 1 + 1 + TAG_W + 1 + TAG_W + CNT_W;

   // ---------------- clock / reset / DUT ----------------
   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    issue_valid, issue_ready, issue_has_rd, flush;
   logic [RA_W-1:0]         issue_rd, issue_rs1, issue_rs2;
   logic [TAG_W-1:0]        issue_tag, rs1_tag, rs2_tag;
   logic [NUM_WB-1:0]       wb_valid;
   logic [NUM_WB*RA_W-1:0]  wb_addr;
   logic [NUM_WB*TAG_W-1:0] wb_tag;
   logic [CNT_W-1:0]        busy_count;

   always #5 clk = ~clk;

   scoreboard_tagged #(
      .REG_COUNT          (REG_COUNT),
      .NUM_WB             (NUM_WB),
      .TAG_W              (TAG_W),
      .ZERO_REG_HARDWIRED (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_rd     (issue_rd),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .issue_has_rd (issue_has_rd),
      .issue_tag    (issue_tag),
      .rs1_tag      (rs1_tag),
      .rs2_tag      (rs2_tag),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .wb_tag       (wb_tag),
      .flush        (flush),
      .busy_count   (busy_count)
   );

   // ---------------- reference model ----------------
   bit               busy_m [REG_COUNT];
   logic [TAG_W-1:0] tag_m  [REG_COUNT];
   wb_port_t         wbp    [NUM_WB];
   logic [EXP_W-1:0] exp_q[$];
   int               n_cmp = 0;
   int               n_err = 0;

   function automatic bit m_clear(input int r);
      bit hit = 1'b0;
      for (int p = 0; p < NUM_WB; p++)
         if (wbp[p].valid && int'(wbp[p].addr) == r && busy_m[r] && wbp[p].tag == tag_m[r]) hit = 1'b1;
      return hit;
   endfunction

   function automatic bit m_avail(input int r);
      return !busy_m[r] || m_clear(r) || (r == 0);
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int r = 0; r < REG_COUNT; r++) n += int'(busy_m[r]);
      return n;
   endfunction

   function automatic void m_clear_all();
      for (int r = 0; r < REG_COUNT; r++) begin
         busy_m[r] = 1'b0;
         tag_m[r]  = '0;
      end
   endfunction

   function automatic wb_port_t wb_none();
      wb_port_t w;
      w = '0;
      return w;
   endfunction

   function automatic wb_port_t wb(input int a, input int t);
      wb_port_t w;
      w.valid = 1'b1;
      w.addr  = RA_W'(a);
      w.tag   = TAG_W'(t);
      return w;
   endfunction

   function automatic wb_port_t rnd_wb();
      wb_port_t w;
      int r = $urandom_range(0, 15);
      w.valid = ($urandom_range(0, 2) != 0);
      w.addr  = RA_W'(r);
      w.tag   = ($urandom_range(0, 1) == 1) ? tag_m[r] : TAG_W'($urandom_range(0, 15));
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      issue_valid  = 1'b0;
      issue_has_rd = 1'b0;
      issue_rd     = '0;
      issue_rs1    = '0;
      issue_rs2    = '0;
      issue_tag    = '0;
      wb_valid     = '0;
      wb_addr      = '0;
      wb_tag       = '0;
      flush        = 1'b0;
   endtask

   // Reset edges are placed just after the monitor sample, with idle inputs so the
   // following clock edge changes nothing whichever side of reset it lands on.
   task automatic set_reset(input bit v);
      @(negedge clk);
      #1;
      idle_inputs();
      rst_n = v;
      if (!v) m_clear_all();
   endtask

   task automatic step(input bit v, input bit has, input int rd, input int rs1, input int rs2,
                       input int tg, input bit fl, input wb_port_t w0, input wb_port_t w1);
      bit rdy;
      bit clr [REG_COUNT];
      @(posedge clk);
      #1;
      issue_valid  = v;
      issue_has_rd = has;
      issue_rd     = RA_W'(rd);
      issue_rs1    = RA_W'(rs1);
      issue_rs2    = RA_W'(rs2);
      issue_tag    = TAG_W'(tg);
      flush        = fl;
      wbp[0]       = w0;
      wbp[1]       = w1;
      wb_valid     = {w1.valid, w0.valid};
      wb_addr      = {w1.addr, w0.addr};
      wb_tag       = {w1.tag, w0.tag};
      for (int r = 0; r < REG_COUNT; r++) clr[r] = m_clear(r);
      rdy = !fl && m_avail(rs1) && m_avail(rs2) && (!has || m_avail(rd));
      exp_q.push_back({rdy, busy_m[rs1], tag_m[rs1], busy_m[rs2], tag_m[rs2], CNT_W'(m_count())});
      if (rst_n) begin
         if (fl) begin
            for (int r = 0; r < REG_COUNT; r++) busy_m[r] = 1'b0;
         end else begin
            for (int r = 0; r < REG_COUNT; r++) if (clr[r]) busy_m[r] = 1'b0;
            if (v && rdy && has && rd != 0) begin
               busy_m[rd] = 1'b1;
               tag_m[rd]  = TAG_W'(tg);
            end
         end
      end
   endtask

   task automatic iss(input int rd, input int rs1, input int rs2, input int tg);
      step(1'b1, 1'b1, rd, rs1, rs2, tg, 1'b0, wb_none(), wb_none());
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   logic             e_rdy, e_b1, e_b2;
   logic [TAG_W-1:0] e_t1, e_t2;
   logic [CNT_W-1:0] e_cnt;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         {e_rdy, e_b1, e_t1, e_b2, e_t2, e_cnt} = exp_q.pop_front();
         chk("issue_ready", 32'(issue_ready), 32'(e_rdy));
         chk("busy_count", 32'(busy_count), 32'(e_cnt));
         if (e_b1) chk("rs1_tag", 32'(rs1_tag), 32'(e_t1));
         if (e_b2) chk("rs2_tag", 32'(rs2_tag), 32'(e_t2));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      rst_n = 1'b0;
      m_clear_all();
      wbp[0] = wb_none();
      wbp[1] = wb_none();

      // Held in reset: everything available, nothing locks.
      iss(5, 1, 2, 3);
      iss(6, 6, 6, 1);
      set_reset(1'b1);

      // Basic lock and source stall.
      iss(5, 1, 2, 3);
      iss(10, 5, 0, 0);
      // Same-cycle writeback bypass on a source.
      step(1'b1, 1'b1, 11, 5, 0, 2, 1'b0, wb_none(), wb(5, 3));
      iss(12, 5, 11, 4);

      // WAW re-issue with a stale writer.
      iss(7, 0, 0, 1);
      step(1'b1, 1'b1, 7, 0, 0, 2, 1'b0, wb(7, 1), wb_none());
      step(1'b0, 1'b0, 0, 7, 0, 0, 1'b0, wb(7, 1), wb_none());
      step(1'b0, 1'b0, 0, 7, 0, 0, 1'b0, wb_none(), wb(7, 2));
      step(1'b0, 1'b0, 0, 7, 0, 0, 1'b0, wb_none(), wb_none());

      // Clear and re-lock of the same register in one cycle.
      iss(9, 0, 0, 4);
      step(1'b1, 1'b1, 9, 0, 0, 6, 1'b0, wb(9, 4), wb_none());
      step(1'b0, 1'b0, 0, 9, 9, 0, 1'b0, wb(9, 4), wb(9, 4));

      // Lock a bank of registers, then flush with an issue pending.
      for (int i = 16; i < 24; i++) iss(i, 0, 0, i);
      step(1'b1, 1'b1, 16, 17, 18, 3, 1'b1, wb_none(), wb_none());
      step(1'b0, 1'b1, 19, 20, 21, 0, 1'b0, wb_none(), wb_none());

      // Hardwired zero register.
      iss(0, 0, 0, 5);
      step(1'b1, 1'b1, 0, 0, 0, 5, 1'b0, wb(0, 5), wb_none());

      // Asynchronous reset with registers locked.
      iss(3, 0, 0, 7);
      iss(4, 0, 0, 8);
      set_reset(1'b0);
      step(1'b0, 1'b1, 3, 4, 3, 0, 1'b0, wb_none(), wb_none());
      set_reset(1'b1);

      // Random traffic over a narrow register window to provoke conflicts.
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            set_reset(1'b0);
            step(1'b0, 1'b0, 0, 1, 2, 0, 1'b0, wb_none(), wb_none());
            set_reset(1'b1);
         end
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 4) != 0),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), ($urandom_range(0, 39) == 0), rnd_wb(), rnd_wb());
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
